// File: rtl/debug_pkg.sv
// Debug-port types shared by the debug arbiter and its users.
package debug_pkg;

   localparam int default_rf_size = 32;

   typedef enum logic [1:0] {
      RUNNING = 2'd0,
      HALTING = 2'd1,
      HALTED  = 2'd2,
      ACCESS  = 2'd3
   } dbg_state_t;

   typedef logic [$clog2(default_rf_size)-1:0] reg_addr_t;

endpackage

// File: rtl/types_pkg.sv
// Core datapath types shared by the register unit and the blocks that drive it.
package types_pkg;

   localparam int xlen      = 32;
   localparam int reg_idx_w = 5;

   typedef logic [xlen-1:0]      word_t;
   typedef logic [reg_idx_w-1:0] reg_idx_t;

   typedef struct packed {
      reg_idx_t rs1;
      reg_idx_t rs2;
      reg_idx_t rd;
      logic     has_rd;
   } instruction_t;

endpackage

// File: rtl/register_debug_arbiter.sv
// Arbitrates register-file access between the core and the debug port; the core is
// frozen at an instruction boundary before any debug read/write is served.
module register_debug_arbiter
   import types_pkg::*;
   import debug_pkg::*;
#(
   parameter int size = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  instruction_t             core_src_instr,
   input  instruction_t             core_dest_instr,
   input  logic                     core_enable,
   input  word_t                    core_xd,
   input  logic                     core_idle,
   output logic                     core_halt,
   input  logic                     dbg_halt_req,
   input  logic                     dbg_resume_req,
   output logic                     dbg_halted,
   input  logic                     dbg_valid,
   output logic                     dbg_ready,
   input  logic                     dbg_write,
   input  logic [$clog2(size)-1:0]  dbg_addr,
   input  word_t                    dbg_wdata,
   output word_t                    dbg_rdata,
   output logic                     dbg_rvalid,
   output instruction_t             rf_src_instr,
   output instruction_t             rf_dest_instr,
   output logic                     rf_enable,
   output word_t                    rf_xd,
   input  word_t                    rf_xs1
);

   localparam int addr_w = $clog2(size);

   dbg_state_t          state_r;
   logic                core_halt_r;
   logic                dbg_halted_r;
   logic                dbg_ready_r;
   logic                dbg_rvalid_r;
   word_t               dbg_rdata_r;
   logic                acc_write_r;
   logic [addr_w-1:0]   acc_addr_r;
   word_t               acc_wdata_r;

   reg_idx_t            acc_idx_s;
   logic                acc_is_x0_s;
   instruction_t        rf_src_s;
   instruction_t        rf_dest_s;
   logic                rf_enable_s;
   word_t               rf_xd_s;

   assign acc_idx_s   = reg_idx_t'(acc_addr_r);
   assign acc_is_x0_s = (acc_addr_r == {addr_w{1'b0}});

   // Control FSM with the latched debug transaction and registered debug outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= RUNNING;
         core_halt_r  <= 1'b0;
         dbg_halted_r <= 1'b0;
         dbg_ready_r  <= 1'b0;
         dbg_rvalid_r <= 1'b0;
         dbg_rdata_r  <= '0;
         acc_write_r  <= 1'b0;
         acc_addr_r   <= '0;
         acc_wdata_r  <= '0;
      end else begin
         dbg_rvalid_r <= 1'b0;
         case (state_r)
            RUNNING: begin
               if (dbg_halt_req) begin
                  state_r     <= HALTING;
                  core_halt_r <= 1'b1;
               end
            end
            HALTING: begin
               // a started halt completes even if the request has been withdrawn
               if (core_idle) begin
                  state_r      <= HALTED;
                  dbg_halted_r <= 1'b1;
                  dbg_ready_r  <= 1'b1;
               end
            end
            HALTED: begin
               if (dbg_valid && dbg_ready_r) begin
                  state_r     <= ACCESS;
                  dbg_ready_r <= 1'b0;
                  acc_write_r <= dbg_write;
                  acc_addr_r  <= dbg_addr;
                  acc_wdata_r <= dbg_wdata;
               end else if (dbg_resume_req) begin
                  state_r      <= RUNNING;
                  core_halt_r  <= 1'b0;
                  dbg_halted_r <= 1'b0;
                  dbg_ready_r  <= 1'b0;
               end
            end
            ACCESS: begin
               state_r     <= HALTED;
               dbg_ready_r <= 1'b1;
               if (!acc_write_r) begin
                  dbg_rdata_r  <= acc_is_x0_s ? '0 : rf_xs1;
                  dbg_rvalid_r <= 1'b1;
               end
            end
            default: begin
               state_r      <= RUNNING;
               core_halt_r  <= 1'b0;
               dbg_halted_r <= 1'b0;
               dbg_ready_r  <= 1'b0;
            end
         endcase
      end
   end

   // Register-unit port mux: core pass-through, quiesced while halted, debug access in ACCESS
   always_comb begin
      rf_src_s    = core_src_instr;
      rf_dest_s   = core_dest_instr;
      rf_enable_s = core_enable;
      rf_xd_s     = core_xd;
      case (state_r)
         RUNNING, HALTING: begin
            rf_enable_s = core_enable;
         end
         HALTED: begin
            rf_src_s    = '0;
            rf_dest_s   = '0;
            rf_enable_s = 1'b0;
         end
         ACCESS: begin
            rf_src_s     = '0;
            rf_src_s.rs1 = acc_idx_s;
            rf_dest_s    = '0;
            if (acc_write_r) begin
               rf_dest_s.rd     = acc_idx_s;
               rf_dest_s.has_rd = 1'b1;
               rf_xd_s          = acc_wdata_r;
               rf_enable_s      = !acc_is_x0_s;
            end else begin
               rf_enable_s = 1'b0;
            end
         end
         default: begin
            rf_src_s    = '0;
            rf_dest_s   = '0;
            rf_enable_s = 1'b0;
         end
      endcase
   end

   // reset also blocks the strobe so an in-flight debug write is aborted
   assign rf_enable     = rf_enable_s & ~reset;
   assign rf_src_instr  = rf_src_s;
   assign rf_dest_instr = rf_dest_s;
   assign rf_xd         = rf_xd_s;

   assign core_halt  = core_halt_r;
   assign dbg_halted = dbg_halted_r;
   assign dbg_ready  = dbg_ready_r;
   assign dbg_rvalid = dbg_rvalid_r;
   assign dbg_rdata  = dbg_rdata_r;

endmodule

// File: tb/tb_register_debug_arbiter.sv
// Self-checking bench for register_debug_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a behavioural model.
module tb_register_debug_arbiter;
   import types_pkg::*;

   localparam int M_RUN     = 0;
   localparam int M_HALTING = 1;
   localparam int M_HALTED  = 2;
   localparam int M_ACCESS  = 3;

   logic         clk = 1'b0;
   logic         reset;
   instruction_t core_src_instr;
   instruction_t core_dest_instr;
   logic         core_enable;
   word_t        core_xd;
   logic         core_idle;
   logic         core_halt;
   logic         dbg_halt_req;
   logic         dbg_resume_req;
   logic         dbg_halted;
   logic         dbg_valid;
   logic         dbg_ready;
   logic         dbg_write;
   logic [4:0]   dbg_addr;
   word_t        dbg_wdata;
   word_t        dbg_rdata;
   logic         dbg_rvalid;
   instruction_t rf_src_instr;
   instruction_t rf_dest_instr;
   logic         rf_enable;
   word_t        rf_xd;
   word_t        rf_xs1;

   int n_vec = 0;
   int n_err = 0;

   word_t regs     [32];
   word_t ref_regs [32];

   always #5 clk = ~clk;

   register_debug_arbiter #(.size(32)) dut (
      .clk(clk), .reset(reset),
      .core_src_instr(core_src_instr), .core_dest_instr(core_dest_instr),
      .core_enable(core_enable), .core_xd(core_xd), .core_idle(core_idle),
      .core_halt(core_halt), .dbg_halt_req(dbg_halt_req), .dbg_resume_req(dbg_resume_req),
      .dbg_halted(dbg_halted), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
      .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
      .rf_src_instr(rf_src_instr), .rf_dest_instr(rf_dest_instr),
      .rf_enable(rf_enable), .rf_xd(rf_xd), .rf_xs1(rf_xs1)
   );

   assign rf_xs1 = regs[rf_src_instr.rs1];

   function automatic word_t init_val(input int i);
      return (i == 0) ? 32'hBAD0_BAD0 : (32'hA500_0000 | 32'(i));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one debug access starting now (cycle N), returning at the negedge of N+2
   task automatic dbg_access(input logic w, input logic [4:0] a, input word_t d);
      dbg_valid = 1'b1; dbg_write = w; dbg_addr = a; dbg_wdata = d;
      @(negedge clk);
      chk("acc_ready_N", 32'(dbg_ready), 32'h1);
      step();
      dbg_valid = 1'b0;
      @(negedge clk);
      chk("acc_ready_N1", 32'(dbg_ready), 32'h0);
      chk("acc_halted_N1", 32'(dbg_halted), 32'h1);
      chk("acc_rvalid_N1", 32'(dbg_rvalid), 32'h0);
      chk("acc_rs1_N1", 32'(rf_src_instr.rs1), 32'(a));
      if (w) begin
         chk("acc_wr_en", 32'(rf_enable), (a != 5'd0) ? 32'h1 : 32'h0);
         chk("acc_wr_xd", rf_xd, d);
      end else begin
         chk("acc_rd_en", 32'(rf_enable), 32'h0);
      end
      step();
      @(negedge clk);
      chk("acc_ready_N2", 32'(dbg_ready), 32'h1);
      chk("acc_rvalid_N2", 32'(dbg_rvalid), w ? 32'h0 : 32'h1);
   endtask

   task automatic halt_core();
      int k;
      step();
      dbg_halt_req = 1'b1; core_idle = 1'b1;
      step();
      dbg_halt_req = 1'b0;
      k = 0;
      while (dbg_halted !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      chk("halt_reached", 32'(dbg_halted), 32'h1);
   endtask

   // Register-unit stand-in and behavioural model, evaluated mid-cycle
   initial begin
      int           mode;
      logic         a_w;
      logic [4:0]   a_addr;
      word_t        a_data;
      logic         rv;
      word_t        rd_exp;
      bit           chk_en;
      bit           chk_xd;
      instruction_t e_src, e_dst;
      logic         e_en;
      word_t        e_xd;
      mode = M_RUN; a_w = 1'b0; a_addr = 5'd0; a_data = '0; rv = 1'b0; rd_exp = '0; chk_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         regs[i]     = init_val(i);
         ref_regs[i] = init_val(i);
      end
      forever begin
         @(negedge clk);
         if (rf_enable === 1'b1) regs[rf_dest_instr.rd] = rf_xd;

         e_src = core_src_instr; e_dst = core_dest_instr; e_en = core_enable; e_xd = core_xd;
         chk_xd = 1'b1;
         if (mode == M_HALTED) begin
            e_src = '0; e_dst = '0; e_en = 1'b0; chk_xd = 1'b0;
         end else if (mode == M_ACCESS) begin
            e_src = '0; e_src.rs1 = a_addr; e_dst = '0; e_en = 1'b0; chk_xd = 1'b0;
            if (a_w) begin
               e_dst.rd = a_addr; e_dst.has_rd = 1'b1; e_xd = a_data; chk_xd = 1'b1;
               e_en = (a_addr != 5'd0);
            end
         end
         if (reset) e_en = 1'b0;

         if (chk_en) begin
            chk("m_core_halt", 32'(core_halt), (mode != M_RUN) ? 32'h1 : 32'h0);
            chk("m_halted", 32'(dbg_halted), (mode >= M_HALTED) ? 32'h1 : 32'h0);
            chk("m_ready", 32'(dbg_ready), (mode == M_HALTED) ? 32'h1 : 32'h0);
            chk("m_rvalid", 32'(dbg_rvalid), 32'(rv));
            chk("m_rdata", dbg_rdata, rd_exp);
            chk("m_rf_enable", 32'(rf_enable), 32'(e_en));
            chk("m_rf_src", 32'(rf_src_instr), 32'(e_src));
            chk("m_rf_dest", 32'(rf_dest_instr), 32'(e_dst));
            if (chk_xd) chk("m_rf_xd", rf_xd, e_xd);
         end

         if (reset) begin
            mode = M_RUN; rv = 1'b0; rd_exp = '0; chk_en = 1'b1;
         end else begin
            if (e_en) ref_regs[e_dst.rd] = e_xd;
            rv = 1'b0;
            if (mode == M_RUN) begin
               if (dbg_halt_req) mode = M_HALTING;
            end else if (mode == M_HALTING) begin
               if (core_idle) mode = M_HALTED;
            end else if (mode == M_HALTED) begin
               if (dbg_valid) begin
                  a_w = dbg_write; a_addr = dbg_addr; a_data = dbg_wdata; mode = M_ACCESS;
               end else if (dbg_resume_req) begin
                  mode = M_RUN;
               end
            end else begin
               if (!a_w) begin
                  rv = 1'b1;
                  rd_exp = (a_addr == 5'd0) ? 32'h0 : ref_regs[a_addr];
               end
               mode = M_HALTED;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   // Directed scenarios followed by randomized traffic
   initial begin
      reset = 1'b1; core_src_instr = '0; core_dest_instr = '0; core_enable = 1'b0; core_xd = '0;
      core_idle = 1'b0; dbg_halt_req = 1'b0; dbg_resume_req = 1'b0; dbg_valid = 1'b0;
      dbg_write = 1'b0; dbg_addr = 5'd0; dbg_wdata = '0;
      repeat (3) step();

      core_enable = 1'b1; core_dest_instr.rd = 5'd5; core_dest_instr.has_rd = 1'b1;
      core_xd = 32'h0000_1234;
      @(negedge clk);
      chk("rst_rf_enable", 32'(rf_enable), 32'h0);
      chk("rst_core_halt", 32'(core_halt), 32'h0);
      chk("rst_ready", 32'(dbg_ready), 32'h0);
      chk("rst_rdata", dbg_rdata, 32'h0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("core_wr_en", 32'(rf_enable), 32'h1);
      chk("core_wr_rd", 32'(rf_dest_instr.rd), 32'h5);
      chk("core_wr_xd", rf_xd, 32'h0000_1234);

      step();
      core_enable = 1'b0; dbg_halt_req = 1'b1;
      step();
      dbg_halt_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("halting_core_halt", 32'(core_halt), 32'h1);
         chk("halting_halted", 32'(dbg_halted), 32'h0);
         step();
      end
      core_idle = 1'b1;
      @(negedge clk);
      chk("idle_core_halt", 32'(core_halt), 32'h1);
      chk("idle_halted", 32'(dbg_halted), 32'h0);
      step();
      core_idle = 1'b0;
      core_enable = 1'b1; core_dest_instr.rd = 5'd3; core_dest_instr.has_rd = 1'b1;
      core_xd = 32'hFFFF_0003;
      @(negedge clk);
      chk("halted_rise", 32'(dbg_halted), 32'h1);
      chk("halted_mask_en", 32'(rf_enable), 32'h0);

      step();
      core_enable = 1'b0;
      dbg_access(1'b1, 5'd7, 32'hDEAD_BEEF);
      step();
      dbg_access(1'b0, 5'd7, 32'h0);
      chk("rd_x7", dbg_rdata, 32'hDEAD_BEEF);
      step();
      @(negedge clk);
      chk("rd_x7_hold", dbg_rdata, 32'hDEAD_BEEF);
      chk("rvalid_pulse", 32'(dbg_rvalid), 32'h0);
      step();
      dbg_access(1'b1, 5'd0, 32'hFFFF_FFFF);
      step();
      dbg_access(1'b0, 5'd0, 32'h0);
      chk("rd_x0", dbg_rdata, 32'h0);
      step();
      dbg_access(1'b0, 5'd3, 32'h0);
      chk("rd_x3_unwritten", dbg_rdata, 32'hA500_0003);

      step();
      dbg_valid = 1'b1; dbg_write = 1'b0; dbg_addr = 5'd5; dbg_resume_req = 1'b1;
      @(negedge clk);
      chk("race_ready", 32'(dbg_ready), 32'h1);
      step();
      dbg_valid = 1'b0;
      @(negedge clk);
      chk("race_access_halt", 32'(core_halt), 32'h1);
      chk("race_access_ready", 32'(dbg_ready), 32'h0);
      step();
      @(negedge clk);
      chk("race_back_halted", 32'(dbg_halted), 32'h1);
      chk("race_rvalid", 32'(dbg_rvalid), 32'h1);
      chk("race_rd_x5", dbg_rdata, 32'h0000_1234);
      step();
      dbg_resume_req = 1'b0;
      @(negedge clk);
      chk("resume_core_halt", 32'(core_halt), 32'h0);
      chk("resume_halted", 32'(dbg_halted), 32'h0);

      halt_core();
      dbg_valid = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h55AA_55AA;
      step();
      dbg_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      chk("rst_acc_en", 32'(rf_enable), 32'h0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_acc_core_halt", 32'(core_halt), 32'h0);
      chk("rst_acc_halted", 32'(dbg_halted), 32'h0);
      chk("rst_acc_ready", 32'(dbg_ready), 32'h0);
      chk("rst_acc_rvalid", 32'(dbg_rvalid), 32'h0);
      chk("rst_acc_rdata", dbg_rdata, 32'h0);
      halt_core();
      dbg_access(1'b0, 5'd9, 32'h0);
      chk("rd_x9_unchanged", dbg_rdata, 32'hA500_0009);
      step();
      dbg_resume_req = 1'b1;
      step();
      dbg_resume_req = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         step();
         reset           = ($urandom_range(0, 199) == 0);
         dbg_halt_req    = ($urandom_range(0, 9) == 0);
         dbg_resume_req  = ($urandom_range(0, 15) == 0);
         core_idle       = ($urandom_range(0, 2) == 0);
         dbg_valid       = 1'($urandom_range(0, 1));
         dbg_write       = 1'($urandom_range(0, 1));
         dbg_addr        = 5'($urandom_range(0, 7));
         dbg_wdata       = $urandom;
         core_src_instr  = 16'($urandom);
         core_dest_instr = 16'($urandom);
         core_enable     = 1'($urandom_range(0, 1));
         core_xd         = $urandom;
      end
      step();
      reset = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/register_debug_arbiter.md
# register_debug_arbiter

Shares the general-purpose register file between the core datapath and an external debug port. During normal execution the core's read selectors and writeback pass straight through to `register_unit`. On a debug halt request the block freezes the core at an instruction boundary. While the core is halted, it serves single-register read and write transactions over a valid/ready handshake, then resumes the core on request.

## Interface
Parameters:
- `size`, default 32: number of registers; the debug address width is `$clog2(size)`.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `core_src_instr`  in  instruction_t: core read selectors (`rs1`, `rs2`).
- `core_dest_instr`  in  instruction_t: core writeback selector (`rd`, `has_rd`).
- `core_enable`  in  1: core writeback strobe.
- `core_xd`  in  word_t: core writeback data.
- `core_idle`  in  1: core is at an instruction boundary with no writeback pending.
- `core_halt`  out  1: freeze the core.
- `dbg_halt_req`  in  1: level; request a halt.
- `dbg_resume_req`  in  1: level; request a resume.
- `dbg_halted`  out  1: core is halted and the debug port is usable.
- `dbg_valid`  in  1: access request.
- `dbg_ready`  out  1: access accepted when `dbg_valid` is also high.
- `dbg_write`  in  1: 1 = write, 0 = read.
- `dbg_addr`  in  `$clog2(size)`: register index.
- `dbg_wdata`  in  word_t: write data.
- `dbg_rdata`  out  word_t: read data.
- `dbg_rvalid`  out  1: one-cycle pulse qualifying `dbg_rdata`.
- `rf_src_instr`  out  instruction_t: to the register unit.
- `rf_dest_instr`  out  instruction_t: to the register unit.
- `rf_enable`  out  1: to the register unit.
- `rf_xd`  out  word_t: to the register unit.
- `rf_xs1`  in  word_t: from the register unit.

## Operation
- States are RUNNING, HALTING, HALTED and ACCESS. Reset enters RUNNING.
- **RUNNING**:
  - `rf_*` outputs equal the `core_*` inputs; `core_halt` = 0.
  - `dbg_halt_req` → HALTING.
- **HALTING**:
  - `core_halt` = 1; core writeback still passes through.
  - `core_idle` → HALTED. The transition is taken even if `dbg_halt_req` has dropped; a halt, once started, completes.
- **HALTED**:
  - `core_halt` = 1, `dbg_halted` = 1, `dbg_ready` = 1.
  - `core_enable` is masked, so `rf_enable` = 0.
  - On handshake (`dbg_valid & dbg_ready`): latch write flag, address and data → ACCESS.
  - Otherwise, `dbg_resume_req` → RUNNING.
  - If a handshake and a resume request occur in the same cycle, the access wins and the resume is ignored for that cycle (resume is level, so it takes effect once back in HALTED).
- **ACCESS** (one cycle):
  - `dbg_ready` = 0; `core_halt` = 1; `dbg_halted` = 1.
  - `rf_src_instr.rs1` = latched address.
  - Write: `rf_dest_instr.rd` = latched address, `has_rd` = 1, `rf_xd` = latched data, `rf_enable` = 1.
  - Write to address 0: `rf_enable` = 0, so the write is dropped.
  - Read: `rf_xs1` is registered into `dbg_rdata`, forced to 0 for address 0.
  - Always returns to HALTED.
- **Register-unit selectors when halted**:
  - In HALTED, the `rf_*instr` fields are zero.
  - In ACCESS, all `rf_*instr` fields not named above are zero.
- **Reset**:
  - Reset mid-ACCESS aborts the access: no write, no `dbg_rvalid`.

## Timing
- Reset values: `core_halt` = 0, `dbg_halted` = 0, `dbg_ready` = 0, `dbg_rvalid` = 0, `dbg_rdata` = 0, `rf_enable` = 0.
- `dbg_halted` rises in the first cycle in HALTED, i.e. one cycle after `core_idle` is sampled high in HALTING.
- **Write**: accepted in cycle N; the register unit is written at the clock edge ending cycle N+1; `dbg_ready` is high again in N+2.
- **Read**: accepted in cycle N; `dbg_rdata` is valid and `dbg_rvalid` = 1 in cycle N+2 only; `dbg_ready` is high again in N+2.
- Maximum throughput is one access per two cycles.
- `dbg_rdata` holds its value until the next read completes.
- **Resume**: sampled in HALTED in cycle N; `core_halt` = 0 in N+1.

## Structure
- A shared `debug_pkg` holds:
  - `dbg_state_t` enum (RUNNING, HALTING, HALTED, ACCESS);
  - `reg_addr_t` (5-bit, for the default `size`).
- `word_t` and `instruction_t` come from `types_pkg`.
- No sub-module: a single FSM plus a datapath mux.

## Test plan
- Core writes x5 = 0x1234 in RUNNING → register unit receives `rf_enable` = 1, rd = 5, xd = 0x1234 in the same cycle.
- Halt with `core_idle` held low for 3 cycles, then high → `core_halt` stays 1 throughout; `dbg_halted` rises exactly one cycle after `core_idle` rises.
- Halted; write x7 = 0xDEADBEEF, then read x7 → the read returns 0xDEADBEEF with `dbg_rvalid` two cycles after acceptance; `dbg_ready` is low in each ACCESS cycle.
- Halted; write x0 = 0xFFFFFFFF, then read x0 → `rf_enable` stays 0 throughout; the read returns 0.
- Halted; `core_enable` = 1 with rd = 3 → no register write occurs. Then `dbg_valid` and `dbg_resume_req` high together → the access completes first, then RUNNING is entered the cycle after the return to HALTED.
- Reset asserted during ACCESS of a write → register unchanged, FSM in RUNNING, all outputs at their reset values.
